// File: rtl/alu_pkg.sv
// Shared ALU / arbiter definitions: opcode encoding, arbiter FSM states,
// and the opcode-legality helper used when forcing results.
`timescale 1ns/1ps
package alu_pkg;

    localparam int ALU_OPCODE_WIDTH = 3;

    typedef enum logic [ALU_OPCODE_WIDTH-1:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // Codes 3'b100..3'b111 are undefined; the MSB alone identifies them.
    function automatic logic op_is_legal(input logic [ALU_OPCODE_WIDTH-1:0] opc);
        return (opc[ALU_OPCODE_WIDTH-1] == 1'b0);
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU: add, subtract, and, or on DATA_WIDTH operands.
// Undefined opcodes produce zero; the caller decides how to flag them.
`timescale 1ns/1ps
module alu
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic [DATA_WIDTH-1:0]       a_i,
    input  logic [DATA_WIDTH-1:0]       b_i,
    input  logic [ALU_OPCODE_WIDTH-1:0] op_i,
    output logic [DATA_WIDTH-1:0]       result_o,
    output logic                        zero_o
);

    // Opcode decode; arithmetic wraps modulo 2^DATA_WIDTH
    always_comb begin
        result_o = '0;
        case (op_i)
            OP_ADD:  result_o = a_i + b_i;
            OP_SUB:  result_o = a_i - b_i;
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            default: result_o = '0;
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin picker: scans the request vector upward from ptr_i, wrapping,
// and returns the first set bit as a one-hot grant plus its index.
`timescale 1ns/1ps
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
    output logic [NUM_REQ-1:0]         grant_o,
    output logic [$clog2(NUM_REQ)-1:0] idx_o,
    output logic                       valid_o
);

    localparam int IDX_W = $clog2(NUM_REQ);

    int               pos;
    logic [IDX_W-1:0] sel;

    // Priority scan starting at the pointer; first hit wins
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        pos     = 0;
        sel     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = int'(ptr_i) + k;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            sel = IDX_W'(pos);
            if (!valid_o && req_i[sel]) begin
                valid_o      = 1'b1;
                grant_o[sel] = 1'b1;
                idx_o        = sel;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between NUM_REQ requesters. Requests are granted round-robin
// in IDLE, operands are latched, the ALU runs from registers in EXEC, and the
// registered response is held in RESP until the granted requester takes it.
// Optional grant counters are built when ALU_ARB_PERF_EN is defined.
`timescale 1ns/1ps
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_REQ    = 2
) (
    input  logic                                         clk_in,
    input  logic                                         rstN_in,
    input  logic [NUM_REQ-1:0]                           reqValid_in,
    output logic [NUM_REQ-1:0]                           reqReady_out,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]           reqOperand1_in,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]           reqOperand2_in,
    input  logic [NUM_REQ-1:0][ALU_OPCODE_WIDTH-1:0]     reqOpcode_in,
    output logic [NUM_REQ-1:0]                           rspValid_out,
    input  logic [NUM_REQ-1:0]                           rspReady_in,
    output logic [DATA_WIDTH-1:0]                        rspResult_out,
    output logic                                         rspZeroFlag_out,
    output logic                                         rspIllegal_out,
    output logic [NUM_REQ-1:0][31:0]                     grantCount_out
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t                  state_q, state_d;
    logic [IDX_W-1:0]            rrPtr_q, rrPtr_d;
    logic [IDX_W-1:0]            grantIdx_q, grantIdx_d;
    logic [DATA_WIDTH-1:0]       op1_q, op1_d;
    logic [DATA_WIDTH-1:0]       op2_q, op2_d;
    logic [ALU_OPCODE_WIDTH-1:0] opc_q, opc_d;
    logic [DATA_WIDTH-1:0]       result_q, result_d;
    logic                        zero_q, zero_d;
    logic                        illegal_q, illegal_d;

    logic [NUM_REQ-1:0]          winGrant;
    logic [IDX_W-1:0]            winIdx;
    logic                        winValid;
    logic                        reqHs;
    logic [DATA_WIDTH-1:0]       aluResult;
    logic                        aluZero;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req_i   (reqValid_in),
        .ptr_i   (rrPtr_q),
        .grant_o (winGrant),
        .idx_o   (winIdx),
        .valid_o (winValid)
    );

    alu #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_alu (
        .a_i      (op1_q),
        .b_i      (op2_q),
        .op_i     (opc_q),
        .result_o (aluResult),
        .zero_o   (aluZero)
    );

    // A grant is only offered in IDLE, so winValid there is the handshake
    assign reqHs        = (state_q == IDLE) && winValid;
    assign reqReady_out = (state_q == IDLE) ? winGrant : '0;

    // Response valid is steered one-hot to the requester that owns the result
    always_comb begin
        rspValid_out = '0;
        if (state_q == RESP) begin
            rspValid_out[grantIdx_q] = 1'b1;
        end
    end

    assign rspResult_out   = result_q;
    assign rspZeroFlag_out = zero_q;
    assign rspIllegal_out  = illegal_q;

    // FSM next state: IDLE -> EXEC on handshake, EXEC -> RESP, RESP -> IDLE on accept
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (reqHs) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rspReady_in[grantIdx_q]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_in or negedge rstN_in) begin
        if (!rstN_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath next state: latch request on handshake, capture ALU output in EXEC
    always_comb begin
        rrPtr_d    = rrPtr_q;
        grantIdx_d = grantIdx_q;
        op1_d      = op1_q;
        op2_d      = op2_q;
        opc_d      = opc_q;
        result_d   = result_q;
        zero_d     = zero_q;
        illegal_d  = illegal_q;
        if (reqHs) begin
            op1_d      = reqOperand1_in[winIdx];
            op2_d      = reqOperand2_in[winIdx];
            opc_d      = reqOpcode_in[winIdx];
            grantIdx_d = winIdx;
            rrPtr_d    = (winIdx == IDX_W'(NUM_REQ - 1)) ? '0 : winIdx + 1'b1;
        end
        if (state_q == EXEC) begin
            if (op_is_legal(opc_q)) begin
                result_d  = aluResult;
                zero_d    = aluZero;
                illegal_d = 1'b0;
            end else begin
                result_d  = '0;
                zero_d    = 1'b1;
                illegal_d = 1'b1;
            end
        end
    end

    // Datapath registers; everything clears so an in-flight op is dropped on reset
    always_ff @(posedge clk_in or negedge rstN_in) begin
        if (!rstN_in) begin
            rrPtr_q    <= '0;
            grantIdx_q <= '0;
            op1_q      <= '0;
            op2_q      <= '0;
            opc_q      <= '0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            rrPtr_q    <= rrPtr_d;
            grantIdx_q <= grantIdx_d;
            op1_q      <= op1_d;
            op2_q      <= op2_d;
            opc_q      <= opc_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            illegal_q  <= illegal_d;
        end
    end

`ifdef ALU_ARB_PERF_EN
    logic [NUM_REQ-1:0][31:0] cnt_q, cnt_d;

    // Saturating per-requester grant counters
    always_comb begin
        cnt_d = cnt_q;
        if (reqHs && (cnt_q[winIdx] != 32'hFFFF_FFFF)) begin
            cnt_d[winIdx] = cnt_q[winIdx] + 32'd1;
        end
    end

    // Grant counter registers
    always_ff @(posedge clk_in or negedge rstN_in) begin
        if (!rstN_in) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign grantCount_out = cnt_q;
`else
    assign grantCount_out = '0;
`endif

endmodule
